tpu_mac_array: RTL and testbench

TPU_MAC_ARRAY -- requirements
Module: tpu_mac_array

---
 rtl/tpu_mac_array.sv | 221 ++++++++++++++++++++++
 tb/tb_tpu_mac_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_mac_array.sv
// Multi-lane 8-bit minifloat MAC array with saturating signed accumulators
// and a flush-then-drain readout sequencer.
module tpu_mac_array #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 34,
  parameter int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_clear,
  input  logic [8*LANES-1:0]   a,
  input  logic [8*LANES-1:0]   b,
  input  logic                 drain,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        out_lane,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_err
);

  // Scaled product is at most 8 mantissa bits shifted by 28; keep headroom.
  localparam int unsigned MW = (ACC_W > 40) ? ACC_W : 40;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LW-1:0]    LAST    = LW'(LANES - 1);

  typedef struct packed {
    logic       sign;
    logic [7:0] mant;
    logic [4:0] shift;
  } s1_t;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             flush_cnt, flush_cnt_nxt;
  logic [LW-1:0]    idx, idx_nxt;
  logic             drain_done;
  logic             accept;

  s1_t              s1_q    [LANES];
  logic             s1_vld, s1_clr;
  logic [ACC_W-1:0] s2_prod [LANES];
  logic             s2_ovf  [LANES];
  logic             s2_vld, s2_clr;

  logic [ACC_W-1:0] acc_q   [LANES];
  logic [ACC_W-1:0] acc_nxt [LANES];
  logic             err_q   [LANES];
  logic             err_nxt [LANES];
  logic [ACC_W:0]   add_res [LANES];

  // Decode both operands into product sign, mantissa product and exponent shift.
  function automatic s1_t decode(input logic [7:0] x, input logic [7:0] y);
    logic nx, ny;
    s1_t  r;
    nx      = |x[6:3];
    ny      = |y[6:3];
    r.sign  = x[7] ^ y[7];
    r.mant  = 8'({nx, x[2:0]}) * 8'({ny, y[2:0]});
    r.shift = 5'(x[6:3]) + 5'(y[6:3]) - 5'(nx) - 5'(ny);
    return r;
  endfunction

  // Returns {overflow, signed product}; an overflowing product contributes zero.
  function automatic logic [ACC_W:0] scale(input s1_t s);
    logic [MW-1:0]    mag;
    logic [ACC_W-1:0] mag_t;
    logic             ovf;
    mag   = MW'(s.mant) << s.shift;
    ovf   = |(mag >> (ACC_W - 1));
    mag_t = mag[ACC_W-1:0];
    if (ovf) begin
      return {1'b1, {ACC_W{1'b0}}};
    end
    return {1'b0, s.sign ? -mag_t : mag_t};
  endfunction

  // Returns {saturated, result} of a signed saturating add.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                             input logic [ACC_W-1:0] y);
    logic [ACC_W:0] sum;
    sum = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return {1'b1, sum[ACC_W] ? ACC_MIN : ACC_MAX};
    end
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign accept = in_valid & in_ready;

  // Two-stage product pipeline shared by all lanes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_clr <= 1'b0;
      s2_vld <= 1'b0;
      s2_clr <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i]    <= '0;
        s2_prod[i] <= '0;
        s2_ovf[i]  <= 1'b0;
      end
    end else begin
      s1_vld <= accept;
      s1_clr <= op_clear;
      s2_vld <= s1_vld;
      s2_clr <= s1_clr;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i]                 <= decode(a[8*i +: 8], b[8*i +: 8]);
        {s2_ovf[i], s2_prod[i]} <= scale(s1_q[i]);
      end
    end
  end

  // Accumulator update: replace on clear, saturating add otherwise.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      add_res[i] = sat_add(acc_q[i], s2_prod[i]);
      acc_nxt[i] = acc_q[i];
      err_nxt[i] = err_q[i];
      if (drain_done) begin
        acc_nxt[i] = '0;
        err_nxt[i] = 1'b0;
      end else if (s2_vld) begin
        if (s2_clr) begin
          acc_nxt[i] = s2_prod[i];
          err_nxt[i] = s2_ovf[i];
        end else begin
          acc_nxt[i] = add_res[i][ACC_W-1:0];
          err_nxt[i] = err_q[i] | s2_ovf[i] | add_res[i][ACC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_nxt[i];
        err_q[i] <= err_nxt[i];
      end
    end
  end

  // Readout sequencer next-state logic.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    idx_nxt       = idx;
    drain_done    = 1'b0;
    case (state)
      IDLE: begin
        if (drain) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt) begin
          state_nxt = DRAIN;
          idx_nxt   = '0;
        end else begin
          flush_cnt_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx == LAST) begin
            drain_done = 1'b1;
            state_nxt  = IDLE;
            idx_nxt    = '0;
          end else begin
            idx_nxt = idx + LW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      idx       <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      idx       <= idx_nxt;
    end
  end

  // Outputs are loaded from next-state values so readout lines up with DRAIN entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DRAIN);
      out_lane  <= idx_nxt;
      out_data  <= (state_nxt == DRAIN) ? acc_nxt[idx_nxt] : '0;
      out_err   <= (state_nxt == DRAIN) & err_nxt[idx_nxt];
    end
  end

endmodule

// File: tb/tb_tpu_mac_array.sv
// Directed bench for tpu_mac_array: integer reference model feeding a
// readout scoreboard, checked with immediate assertions.
module tb_tpu_mac_array;

  localparam int unsigned LANES = 4;
  localparam int unsigned ACC_W = 34;
  localparam int unsigned LW    = 2;
  localparam longint      LIM   = 64'sd1 <<< 33;

  logic             clk, reset, in_valid, in_ready, op_clear, drain;
  logic             out_valid, out_ready, out_err;
  logic [31:0]      a, b;
  logic [LW-1:0]    out_lane;
  logic [ACC_W-1:0] out_data;

  typedef struct packed {
    logic [LW-1:0]    lane;
    logic [ACC_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t   sb[$];
  longint macc [LANES];
  logic   merr [LANES];
  int     n_tests = 0;
  int     n_fail  = 0;

  tpu_mac_array #(.LANES(LANES), .ACC_W(ACC_W), .LW(LW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_clear(op_clear), .a(a), .b(b), .drain(drain),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic longint opv(input logic [7:0] x);
    longint m;
    int     e;
    e = int'(x[6:3]);
    if (e == 0) m = longint'(x[2:0]);
    else        m = longint'({1'b1, x[2:0]}) <<< (e - 1);
    return x[7] ? -m : m;
  endfunction

  task automatic model_step(input logic [31:0] av, input logic [31:0] bv, input logic clr);
    longint p, s;
    logic   ovf, sat;
    for (int l = 0; l < LANES; l++) begin
      p   = opv(av[8*l +: 8]) * opv(bv[8*l +: 8]);
      ovf = (p > LIM - 1) || (p < -(LIM - 1));
      if (ovf) p = 0;
      if (clr) begin
        macc[l] = p;
        merr[l] = ovf;
      end else begin
        s   = macc[l] + p;
        sat = 1'b0;
        if (s > LIM - 1) begin s = LIM - 1; sat = 1'b1; end
        else if (s < -LIM) begin s = -LIM; sat = 1'b1; end
        macc[l] = s;
        merr[l] = merr[l] | ovf | sat;
      end
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) begin
      macc[l] = 0;
      merr[l] = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic clr, input logic drn);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    op_clear = clr;
    drain    = drn;
    @(posedge clk);
    model_step(av, bv, clr);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    op_clear = 1'b0;
    drain    = 1'b0;
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1,0,0...
  task automatic do_drain(input bit issue, input int mode);
    exp_t e;
    int   cyc;
    int   k;
    bit   hs;
    if (issue) begin
      @(negedge clk);
      in_valid = 1'b0;
      drain    = 1'b1;
      @(posedge clk);
    end
    for (int l = 0; l < LANES; l++) begin
      e.lane = LW'(l);
      e.data = ACC_W'(macc[l]);
      e.err  = merr[l];
      sb.push_back(e);
    end
    @(negedge clk);
    drain    = 1'b0;
    in_valid = 1'b0;
    op_clear = 1'b0;
    cyc = 0;
    k   = 0;
    while (sb.size() != 0) begin
      if (cyc >= 100) begin
        check("drain_timeout", 64'(sb.size()), 64'(0));
        sb.delete();
        break;
      end
      check("busy_in_ready", 64'(in_ready), 64'(0));
      hs = 1'b0;
      if (out_valid === 1'b1) begin
        e = sb[0];
        check("out_lane", 64'(out_lane), 64'(e.lane));
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_err", 64'(out_err), 64'(e.err));
        hs = (mode == 0) ? 1'b1 : ((k % 3) == 0);
        k++;
      end
      out_ready = hs;
      @(negedge clk);
      cyc++;
      if (hs) void'(sb.pop_front());
    end
    out_ready = 1'b0;
    check("post_drain_in_ready", 64'(in_ready), 64'(1));
    check("post_drain_out_valid", 64'(out_valid), 64'(0));
    model_clear();
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    in_valid  = 1'b0;
    op_clear  = 1'b0;
    drain     = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_lane", 64'(out_lane), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'(1));
    check("rel_out_valid", 64'(out_valid), 64'(0));

    // lane0 sign cancel, lane1 denormal, lane2 product overflow, lane3 positive saturation
    send({8'h77, 8'h08, 8'h03, 8'h08}, {8'h6F, 8'h08, 8'h05, 8'h08}, 1'b1, 1'b0);
    send({8'h77, 8'h7F, 8'h00, 8'h88}, {8'h6F, 8'h7F, 8'hFF, 8'h08}, 1'b0, 1'b0);
    send({8'hF7, 8'h08, 8'h00, 8'h88}, {8'h6F, 8'h08, 8'hFF, 8'h08}, 1'b0, 1'b0);
    do_drain(1'b1, 0);

    // Clear after overflow, negative saturation, drain in same cycle as last vector, stalled readout
    send({8'h00, 8'h7F, 8'h11, 8'h08}, {8'h00, 8'h7F, 8'h22, 8'h08}, 1'b1, 1'b0);
    send({8'hF7, 8'h08, 8'h03, 8'h08}, {8'h6F, 8'h08, 8'h05, 8'h08}, 1'b1, 1'b0);
    send({8'hF7, 8'h00, 8'h00, 8'h88}, {8'h6F, 8'h00, 8'hFF, 8'h88}, 1'b0, 1'b0);
    send({8'h00, 8'h00, 8'h80, 8'h0F}, {8'h00, 8'h00, 8'h80, 8'h08}, 1'b0, 1'b1);
    do_drain(1'b0, 1);

    // Reset while lane 2 is being read out
    send({8'h48, 8'h38, 8'h28, 8'h18}, {8'h08, 8'h08, 8'h08, 8'h08}, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    drain    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drain     = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid === 1'b1 && out_lane === 2'd2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_lane2", 64'(cyc < 50), 64'(1));
    out_ready = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_out_lane", 64'(out_lane), 64'(0));
    check("abort_out_data", 64'(out_data), 64'(0));
    reset = 1'b1;
    model_clear();
    do_drain(1'b1, 0);

    // Reset with a product in flight discards it
    send({8'h08, 8'h08, 8'h08, 8'h08}, {8'h08, 8'h08, 8'h08, 8'h08}, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    do_drain(1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
